// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bus writes queue in a FIFO and are sent as start, data (LSB first),
// optional parity and stop bits, one bit per enable tick. Define UART_TX_PARITY_EN for the parity bit.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iocs,
    input  logic                          iorw,
    input  logic [1:0]                    ioaddr,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             data,
    output logic                          out,
    output logic                          tbr,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);

    if (DATA_W < 5 || DATA_W > 9) begin : gBadDataW
        $error("uart_tx_fifo: DATA_W must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : gBadParity
        $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wrPtr_q, rdPtr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              tbr_q, overflow_q;
    logic              pushReq, pushOk, clearReq, pop;
    logic [DATA_W-1:0] head;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bitCnt_q, bitCnt_d;
    logic              stopCnt_q, stopCnt_d;
    logic              txd_q, txd_d;
    logic              startFrame;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign pushReq  = iocs & ~iorw & (ioaddr == 2'b00);
    assign clearReq = iocs & ~iorw & (ioaddr == 2'b01);
    assign pushOk   = pushReq & (count_q != FULL_COUNT);
    assign head     = mem_q[rdPtr_q];
    assign count_d  = count_q + CW'(pushOk) - CW'(pop);

    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q] <= data;
    end

    // A full FIFO refuses the push even when a pop frees a slot on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            tbr_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)    rdPtr_q <= rdPtr_q + AW'(1);
            count_q <= count_d;
            tbr_q   <= (count_d != FULL_COUNT);
            if (clearReq)
                overflow_q <= 1'b0;
            else if (pushReq && !pushOk)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitCnt_q  <= bitCnt_d;
            stopCnt_q <= stopCnt_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitCnt_d   = bitCnt_q;
        stopCnt_d  = stopCnt_q;
        txd_d      = txd_q;
        startFrame = 1'b0;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) startFrame = 1'b1;
                end
                START: begin
                    txd_d    = shift_q[0];
                    shift_d  = {1'b0, shift_q[DATA_W-1:1]};
                    bitCnt_d = BW'(1);
                    state_d  = DATA;
                end
                DATA: begin
                    if (bitCnt_q != LAST_BIT) begin
                        txd_d    = shift_q[0];
                        shift_d  = {1'b0, shift_q[DATA_W-1:1]};
                        bitCnt_d = bitCnt_q + BW'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = PARITY;
`else
                        txd_d     = 1'b1;
                        stopCnt_d = 1'b0;
                        state_d   = STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    txd_d     = 1'b1;
                    stopCnt_d = 1'b0;
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    if (stopCnt_q != STOP_LAST) begin
                        stopCnt_d = 1'b1;
                    end else if (count_q != '0) begin
                        startFrame = 1'b1;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
        // Loading the head entry drives the start bit on the same tick.
        if (startFrame) begin
            pop     = 1'b1;
            shift_d = head;
            txd_d   = 1'b0;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            parity_d = (^head) ^ PARITY_ODD[0];
`endif
        end
    end

    assign out        = txd_q;
    assign tbr        = tbr_q;
    assign busy       = (state_q != IDLE) | (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
